// File: rtl/ct_l2c_sram_pkg.sv
// Shared widths, controller state encoding and response-buffer depth for the L2C SRAM controller.
package ct_l2c_sram_pkg;

   localparam int ADDR_WIDTH     = 12;
   localparam int DATA_WIDTH     = 128;
   localparam int BE_WIDTH       = DATA_WIDTH / 8;
   localparam int RSP_FIFO_DEPTH = 3;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } ctrl_state_e;

endpackage

// File: rtl/ct_spsram_rsp_fifo.sv
// In-order read-response buffer with a registered head (entry 0), so vld_o/dat_o come straight from flops.
// The caller never pushes when full; pops are ignored when empty.
module ct_spsram_rsp_fifo #(
   parameter int DEPTH = 3,
   parameter int WIDTH = 128,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic             vld_o,
   output logic [WIDTH-1:0] dat_o,
   output logic [CNT_W-1:0] cnt_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] wr_idx;
   logic             pop;

   assign pop   = pop_i & (cnt_q != '0);
   assign vld_o = (cnt_q != '0);
   assign dat_o = mem_q[0];
   assign cnt_o = cnt_q;

   // A simultaneous pop shifts everything down one slot, so the write lands one entry lower.
   always_comb begin
      cnt_d  = cnt_q;
      wr_idx = cnt_q;
      if (pop) begin
         wr_idx = cnt_q - 1'b1;
      end
      if (push_i && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!push_i && pop) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               mem_q[i] <= mem_q[i + 1];
            end
         end
         if (push_i) begin
            mem_q[wr_idx] <= push_dat_i;
         end
      end
   end

endmodule

// File: rtl/ct_spsram_4096x128_ctrl.sv
// Initiator-side controller for the 4096x128 single-port L2C SRAM: optional zero-fill after reset,
// then valid/ready requests driven onto the macro pins with credit-limited, in-order read responses.
module ct_spsram_4096x128_ctrl #(
   parameter int ADDR_WIDTH    = ct_l2c_sram_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH    = ct_l2c_sram_pkg::DATA_WIDTH,
   parameter int BE_WIDTH      = ct_l2c_sram_pkg::BE_WIDTH,
   parameter bit INIT_ON_RESET = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [BE_WIDTH-1:0]   req_be,
   output logic                  rsp_vld,
   input  logic                  rsp_rdy,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic [ADDR_WIDTH-1:0] A,
   output logic                  CEN,
   output logic                  GWEN,
   output logic [DATA_WIDTH-1:0] WEN,
   output logic [DATA_WIDTH-1:0] D,
   input  logic [DATA_WIDTH-1:0] Q
);

   import ct_l2c_sram_pkg::*;

   localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

   ctrl_state_e           state_q;
   logic [ADDR_WIDTH-1:0] init_cnt_q;
   logic                  rd_inflight_q;
   logic                  rd_inflight_d;
   logic [CNT_W-1:0]      fifo_cnt;
   logic                  credit_ok;
   logic                  accept;

   // Every read still outstanding (in flight or buffered) holds one buffer slot.
   assign credit_ok = (int'(fifo_cnt) + int'(rd_inflight_q)) < RSP_FIFO_DEPTH;
   assign init_done = (state_q == ST_RUN) && !RST;

   always_comb begin
      req_rdy       = 1'b0;
      accept        = 1'b0;
      rd_inflight_d = 1'b0;
      A             = '0;
      CEN           = 1'b1;
      GWEN          = 1'b1;
      WEN           = '1;
      D             = '0;
      if (!RST) begin
         if (state_q == ST_INIT) begin
            A    = init_cnt_q;
            CEN  = 1'b0;
            GWEN = 1'b0;
            WEN  = '0;
         end else begin
            req_rdy = req_wr | credit_ok;
            accept  = req_vld & (req_wr | credit_ok);
            if (accept) begin
               A    = req_addr;
               GWEN = ~req_wr;
               if (req_wr) begin
                  // A write with no byte enabled is consumed without touching the macro.
                  CEN = ~|req_be;
                  D   = req_wdata;
                  for (int i = 0; i < BE_WIDTH; i++) begin
                     WEN[8*i +: 8] = {8{~req_be[i]}};
                  end
               end else begin
                  CEN           = 1'b0;
                  rd_inflight_d = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= INIT_ON_RESET ? ST_INIT : ST_RUN;
         init_cnt_q    <= '0;
         rd_inflight_q <= 1'b0;
      end else begin
         rd_inflight_q <= rd_inflight_d;
         if (state_q == ST_INIT) begin
            init_cnt_q <= init_cnt_q + 1'b1;
            if (&init_cnt_q) begin
               state_q <= ST_RUN;
            end
         end
      end
   end

   // Q is valid the cycle after the macro sampled the read, i.e. while rd_inflight_q is set.
   ct_spsram_rsp_fifo #(
      .DEPTH (RSP_FIFO_DEPTH),
      .WIDTH (DATA_WIDTH),
      .CNT_W (CNT_W)
   ) u_rsp_fifo (
      .clk_i      (CLK),
      .rst_i      (RST),
      .push_i     (rd_inflight_q),
      .push_dat_i (Q),
      .pop_i      (rsp_vld & rsp_rdy),
      .vld_o      (rsp_vld),
      .dat_o      (rsp_rdata),
      .cnt_o      (fifo_cnt)
   );

endmodule
